// File: rtl/rv32_pkg.sv
// Shared encodings for the multicycle RV32I core: opcodes, funct fields,
// ALU operations, FSM states and the default reset PC.
package rv32_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_FETCH, ST_EXEC, ST_HALTED
  } state_e;

  // Map funct3 (plus the alternate-encoding bit) onto an ALU operation.
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// 32-bit integer ALU with compare flags used for branch resolution.
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     alu_op,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  // Compare flags and result selection.
  always_comb begin
    eq  = (a == b);
    lt  = ($signed(a) < $signed(b));
    ltu = (a < b);
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'b0, lt};
      ALU_SLTU: result = {31'b0, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv32_cpu_core.sv
// Multicycle RV32I core (ALU/branch/jump subset): FETCH/EXEC at CPI=2,
// sticky halt on zero, system or unsupported instructions.
module rv32_cpu_core
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [31:0] inst,
  output logic [31:0] next_inst_addr,
  output logic        read_enable_cpu,
  output logic        halt,
  input  logic [4:0]  dbg_reg_addr,
  output logic [31:0] dbg_reg_data
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        halt_q, halt_d;
  logic        read_enable_q, read_enable_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_u, imm_b, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4, pc_target, pc_next;
  logic [31:0] alu_a, alu_b, alu_result, wr_data;
  alu_op_e     alu_op;
  logic        alu_eq, alu_lt, alu_ltu, legal, wr_en, taken;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign rs1_val   = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_val   = (rs2 == 5'd0) ? '0 : regs_q[rs2];
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_target = pc_q + ((opcode == OPC_JAL) ? imm_j : imm_b);

  rv32_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_result),
    .eq     (alu_eq),
    .lt     (alu_lt),
    .ltu    (alu_ltu)
  );

  // Instruction decode: operand selection, legality, writeback and next PC.
  always_comb begin
    alu_a   = rs1_val;
    alu_b   = rs2_val;
    alu_op  = ALU_ADD;
    legal   = 1'b0;
    wr_en   = 1'b0;
    wr_data = alu_result;
    taken   = 1'b0;
    pc_next = pc_plus4;
    case (opcode)
      OPC_LUI: begin
        legal   = 1'b1;
        wr_en   = 1'b1;
        wr_data = imm_u;
      end
      OPC_AUIPC: begin
        alu_a = pc_q;
        alu_b = imm_u;
        legal = 1'b1;
        wr_en = 1'b1;
      end
      OPC_JAL: begin
        legal   = 1'b1;
        wr_en   = 1'b1;
        wr_data = pc_plus4;
        pc_next = pc_target;
      end
      OPC_JALR: begin
        alu_b   = imm_i;
        legal   = (f3 == 3'd0);
        wr_en   = 1'b1;
        wr_data = pc_plus4;
        pc_next = alu_result & ~32'd1;
      end
      OPC_BRANCH: begin
        legal = 1'b1;
        case (f3)
          F3_BEQ:  taken = alu_eq;
          F3_BNE:  taken = !alu_eq;
          F3_BLT:  taken = alu_lt;
          F3_BGE:  taken = !alu_lt;
          F3_BLTU: taken = alu_ltu;
          F3_BGEU: taken = !alu_ltu;
          default: legal = 1'b0;
        endcase
        if (taken) pc_next = pc_target;
      end
      OPC_OP_IMM: begin
        alu_b  = imm_i;
        alu_op = f3_to_alu(f3, (f3 == F3_SRL_SRA) && inst[30]);
        wr_en  = 1'b1;
        if (f3 == F3_SLL)          legal = (f7 == F7_BASE);
        else if (f3 == F3_SRL_SRA) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        else                       legal = 1'b1;
      end
      OPC_OP: begin
        alu_op = f3_to_alu(f3, f7[5]);
        wr_en  = 1'b1;
        legal  = (f7 == F7_BASE) ||
                 ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)));
      end
      default: legal = 1'b0;
    endcase
    pc_next[1:0] = 2'b00;
  end

  // FSM next-state, PC, register-file and registered-output computation.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    halt_d        = halt_q;
    read_enable_d = 1'b0;
    regs_d        = regs_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d       = ST_FETCH;
          read_enable_d = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (legal) begin
          pc_d = pc_next;
          if (wr_en && (rd != 5'd0)) regs_d[rd] = wr_data;
          state_d       = ST_FETCH;
          read_enable_d = 1'b1;
        end else begin
          state_d = ST_HALTED;
          halt_d  = 1'b1;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      halt_q        <= 1'b0;
      read_enable_q <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      halt_q        <= halt_d;
      read_enable_q <= read_enable_d;
      regs_q        <= regs_d;
    end
  end

  assign next_inst_addr  = pc_q;
  assign read_enable_cpu = read_enable_q;
  assign halt            = halt_q;
  assign dbg_reg_data    = (dbg_reg_addr == 5'd0) ? '0 : regs_q[dbg_reg_addr];

endmodule

// File: tb/tb_rv32_cpu_core.sv
// Self-checking bench for rv32_cpu_core: a ROM model, a fetch-address
// scoreboard and one task per scenario.
module tb_rv32_cpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] next_inst_addr;
  logic        read_enable_cpu;
  logic        halt;
  logic [4:0]  dbg_reg_addr = '0;
  logic [31:0] dbg_reg_data;

  int checks = 0;
  int fails  = 0;

  logic [31:0] rom [16];
  logic [31:0] exp_q [$];
  logic [31:0] exp_addr;
  bit          mon_en = 1'b0;

  rv32_cpu_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .go              (go),
    .inst            (inst),
    .next_inst_addr  (next_inst_addr),
    .read_enable_cpu (read_enable_cpu),
    .halt            (halt),
    .dbg_reg_addr    (dbg_reg_addr),
    .dbg_reg_data    (dbg_reg_data)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word appears the cycle after the strobe.
  always @(posedge clk) if (read_enable_cpu) inst <= rom[next_inst_addr[5:2]];

  // Scoreboard: every observed fetch is popped against the expected address.
  always @(negedge clk) begin
    if (mon_en && read_enable_cpu === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL fetch_extra: got addr=%h, expected no fetch", next_inst_addr);
      end else begin
        exp_addr = exp_q.pop_front();
        if (next_inst_addr !== exp_addr) begin
          fails++;
          $display("FAIL fetch_addr: got %h, expected %h", next_inst_addr, exp_addr);
        end
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = '0;
  endtask

  task automatic push_fetches(input logic [31:0] a [$]);
    foreach (a[i]) exp_q.push_back(a[i]);
  endtask

  // Reset low for two cycles, then release with go asserted.
  task automatic start_prog();
    @(negedge clk);
    reset = 1'b0;
    go = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    go = 1'b1;
  endtask

  task automatic wait_halt(input int max, output int cyc);
    cyc = 0;
    while (halt !== 1'b1 && cyc < max) begin
      @(negedge clk);
      cyc++;
      go = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    go = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (halt !== 1'b0) begin fails++; $display("FAIL reset_halt: got %b, expected 0", halt); end
    checks++;
    if (next_inst_addr !== 32'h0) begin
      fails++; $display("FAIL reset_pc: got %h, expected 00000000", next_inst_addr);
    end
    for (int r = 0; r < 32; r++) begin
      dbg_reg_addr = r[4:0];
      #1;
      checks++;
      if (dbg_reg_data !== 32'h0) begin
        fails++; $display("FAIL reset_reg x%0d: got %h, expected 00000000", r, dbg_reg_data);
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (read_enable_cpu !== 1'b0) begin
        fails++; $display("FAIL idle_no_fetch cycle %0d: got %b, expected 0", c, read_enable_cpu);
      end
    end
  endtask

  task automatic test_add_program();
    int cyc;
    clear_rom();
    rom[0] = 32'h00500093; rom[1] = 32'h00700113; rom[2] = 32'h002081B3; rom[3] = 32'h0;
    push_fetches('{32'd0, 32'd4, 32'd8, 32'd12});
    start_prog();
    wait_halt(100, cyc);
    checks++;
    if (halt !== 1'b1 || cyc != 9) begin
      fails++; $display("FAIL add_halt_timing: halt=%b after %0d edges, expected 1 after 8", halt, cyc - 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (next_inst_addr !== 32'd12) begin
      fails++; $display("FAIL add_halt_addr: got %h, expected 0000000c", next_inst_addr);
    end
    dbg_reg_addr = 5'd1; #1; checks++;
    if (dbg_reg_data !== 32'd5) begin fails++; $display("FAIL add_x1: got %h, expected 5", dbg_reg_data); end
    dbg_reg_addr = 5'd2; #1; checks++;
    if (dbg_reg_data !== 32'd7) begin fails++; $display("FAIL add_x2: got %h, expected 7", dbg_reg_data); end
    dbg_reg_addr = 5'd3; #1; checks++;
    if (dbg_reg_data !== 32'd12) begin fails++; $display("FAIL add_x3: got %h, expected c", dbg_reg_data); end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL add_fetch_missing: %0d left, expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_x0_write();
    int cyc;
    clear_rom();
    rom[0] = 32'h00100013;
    push_fetches('{32'd0, 32'd4});
    start_prog();
    wait_halt(100, cyc);
    checks++;
    if (halt !== 1'b1 || next_inst_addr !== 32'd4) begin
      fails++; $display("FAIL x0_halt: halt=%b addr=%h, expected 1 at 00000004", halt, next_inst_addr);
    end
    dbg_reg_addr = 5'd0; #1; checks++;
    if (dbg_reg_data !== 32'd0) begin fails++; $display("FAIL x0_read: got %h, expected 0", dbg_reg_data); end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL x0_fetch_missing: %0d left, expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_branch_loop();
    int cyc;
    clear_rom();
    rom[0] = 32'h00300093; rom[1] = 32'hFFF08093; rom[2] = 32'hFE009EE3;
    push_fetches('{32'd0, 32'd4, 32'd8, 32'd4, 32'd8, 32'd4, 32'd8, 32'd12});
    start_prog();
    wait_halt(200, cyc);
    checks++;
    if (halt !== 1'b1 || next_inst_addr !== 32'd12) begin
      fails++; $display("FAIL loop_halt: halt=%b addr=%h, expected 1 at 0000000c", halt, next_inst_addr);
    end
    dbg_reg_addr = 5'd1; #1; checks++;
    if (dbg_reg_data !== 32'd0) begin fails++; $display("FAIL loop_x1: got %h, expected 0", dbg_reg_data); end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL loop_fetch_missing: %0d left, expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_immediates();
    int cyc;
    clear_rom();
    rom[0] = 32'h123452B7; rom[1] = 32'hFF800313; rom[2] = 32'h40135393;
    push_fetches('{32'd0, 32'd4, 32'd8, 32'd12});
    start_prog();
    wait_halt(100, cyc);
    checks++;
    if (halt !== 1'b1) begin fails++; $display("FAIL imm_halt_timeout: halt=%b, expected 1", halt); end
    dbg_reg_addr = 5'd5; #1; checks++;
    if (dbg_reg_data !== 32'h12345000) begin fails++; $display("FAIL lui_x5: got %h, expected 12345000", dbg_reg_data); end
    dbg_reg_addr = 5'd6; #1; checks++;
    if (dbg_reg_data !== 32'hFFFFFFF8) begin fails++; $display("FAIL addi_x6: got %h, expected fffffff8", dbg_reg_data); end
    dbg_reg_addr = 5'd7; #1; checks++;
    if (dbg_reg_data !== 32'hFFFFFFFC) begin fails++; $display("FAIL srai_x7: got %h, expected fffffffc", dbg_reg_data); end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL imm_fetch_missing: %0d left, expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_jal();
    int cyc;
    clear_rom();
    rom[0] = 32'h008000EF; rom[1] = 32'h00100093;
    push_fetches('{32'd0, 32'd8});
    start_prog();
    wait_halt(100, cyc);
    checks++;
    if (halt !== 1'b1 || next_inst_addr !== 32'd8) begin
      fails++; $display("FAIL jal_halt: halt=%b addr=%h, expected 1 at 00000008", halt, next_inst_addr);
    end
    dbg_reg_addr = 5'd1; #1; checks++;
    if (dbg_reg_data !== 32'd4) begin fails++; $display("FAIL jal_link: got %h, expected 4", dbg_reg_data); end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL jal_fetch_missing: %0d left, expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_alu_ops();
    int cyc;
    logic [31:0] exp_r [8];
    clear_rom();
    rom[0] = 32'hFFD00093; rom[1] = 32'h00500113; rom[2] = 32'h402081B3; rom[3] = 32'h0020A233;
    rom[4] = 32'h0020B2B3; rom[5] = 32'h0020C333; rom[6] = 32'h0020D3B3; rom[7] = 32'h00000073;
    exp_r = '{32'h0, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFF8, 32'h1, 32'h0, 32'hFFFFFFF8, 32'h07FFFFFF};
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    start_prog();
    wait_halt(100, cyc);
    checks++;
    if (halt !== 1'b1 || next_inst_addr !== 32'd28) begin
      fails++; $display("FAIL ecall_halt: halt=%b addr=%h, expected 1 at 0000001c", halt, next_inst_addr);
    end
    for (int r = 1; r < 8; r++) begin
      dbg_reg_addr = r[4:0]; #1; checks++;
      if (dbg_reg_data !== exp_r[r]) begin
        fails++; $display("FAIL alu_x%0d: got %h, expected %h", r, dbg_reg_data, exp_r[r]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL alu_fetch_missing: %0d left, expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_loop();
    clear_rom();
    rom[0] = 32'h00300093; rom[1] = 32'hFFF08093; rom[2] = 32'hFE009EE3;
    push_fetches('{32'd0, 32'd4, 32'd8});
    start_prog();
    @(negedge clk);
    go = 1'b0;
    repeat (5) @(negedge clk);
    dbg_reg_addr = 5'd1; #1; checks++;
    if (dbg_reg_data !== 32'd2) begin fails++; $display("FAIL mid_x1: got %h, expected 2", dbg_reg_data); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (halt !== 1'b0 || read_enable_cpu !== 1'b0 || next_inst_addr !== 32'd0) begin
      fails++;
      $display("FAIL mid_reset_state: halt=%b re=%b addr=%h, expected 0 0 00000000", halt, read_enable_cpu, next_inst_addr);
    end
    for (int r = 1; r < 4; r++) begin
      dbg_reg_addr = r[4:0]; #1; checks++;
      if (dbg_reg_data !== 32'd0) begin
        fails++; $display("FAIL mid_reset_x%0d: got %h, expected 0", r, dbg_reg_data);
      end
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL mid_fetch_missing: %0d left, expected 0", exp_q.size()); end
    exp_q.delete();
    exp_q.push_back(32'd0);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL restart_fetch: %0d left, expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    clear_rom();
    mon_en = 1'b1;
    test_reset();
    test_add_program();
    test_x0_write();
    test_branch_loop();
    test_immediates();
    test_jal();
    test_alu_ops();
    test_reset_mid_loop();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
